// File: rtl/descriptor_send_queue.sv
// Descriptor sender: merges each descriptor with its allocated buffer ID, queues the
// result in a small circular buffer and hands it to the queue manager with an ack handshake.
module descriptor_send_queue #(
    parameter int DES_W       = 72,
    parameter int BUFID_W     = 9,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 0,
    parameter int CNT_W       = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_descriptor_valid,
    input  logic [DES_W-1:0]           iv_descriptor,
    input  logic                       i_pkt_bufid_wr,
    input  logic [BUFID_W-1:0]         iv_pkt_bufid,
    output logic                       o_pkt_bufid_ack,
    output logic                       o_pkt_bufid_wr,
    output logic [BUFID_W-1:0]         ov_pkt_bufid,
    output logic                       o_descriptor_wr,
    output logic [DES_W-1:0]           ov_descriptor,
    input  logic                       i_descriptor_ack,
    output logic [$clog2(DEPTH):0]     ov_queue_used,
    output logic [CNT_W-1:0]           ov_nobufid_drop_cnt,
    output logic [CNT_W-1:0]           ov_full_drop_cnt,
    output logic [CNT_W-1:0]           ov_timeout_cnt,
    output logic [1:0]                 ov_send_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE_S         = 2'b00,
        WAIT_DES_ACK_S = 2'b10
    } send_state_t;

    send_state_t      state;
    logic [DES_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   used;
    logic [TMR_W-1:0] timer;
    logic             empty;
    logic             full;
    logic             in_pair;
    logic             push;
    logic             pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign empty   = (used == '0);
    assign full    = (used == (PTR_W+1)'(DEPTH));
    assign in_pair = i_descriptor_valid && i_pkt_bufid_wr;
    assign pop     = !empty && ((state == IDLE_S) ||
                                (state == WAIT_DES_ACK_S && i_descriptor_ack));
    // A full queue still accepts a pair when the head leaves on the same edge.
    assign push    = in_pair && (!full || pop);

    assign ov_queue_used = used;
    assign ov_send_state = state;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {iv_descriptor[DES_W-1:BUFID_W], iv_pkt_bufid};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            used                <= '0;
            o_pkt_bufid_ack     <= 1'b0;
            o_pkt_bufid_wr      <= 1'b0;
            ov_pkt_bufid        <= '0;
            ov_nobufid_drop_cnt <= '0;
            ov_full_drop_cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            used            <= used + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            o_pkt_bufid_ack <= push;
            o_pkt_bufid_wr  <= push;
            ov_pkt_bufid    <= push ? iv_pkt_bufid : '0;
            if (i_descriptor_valid && !i_pkt_bufid_wr) begin
                ov_nobufid_drop_cnt <= sat_inc(ov_nobufid_drop_cnt);
            end
            // No bufid ack on a full drop, so upstream keeps ownership of the ID.
            if (in_pair && full && !pop) begin
                ov_full_drop_cnt <= sat_inc(ov_full_drop_cnt);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE_S;
            o_descriptor_wr <= 1'b0;
            ov_descriptor   <= '0;
            timer           <= '0;
            ov_timeout_cnt  <= '0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (!empty) begin
                        o_descriptor_wr <= 1'b1;
                        ov_descriptor   <= mem[rd_ptr];
                        timer           <= '0;
                        state           <= WAIT_DES_ACK_S;
                    end
                end
                WAIT_DES_ACK_S: begin
                    if (i_descriptor_ack) begin
                        if (!empty) begin
                            ov_descriptor <= mem[rd_ptr];
                            timer         <= '0;
                        end else begin
                            o_descriptor_wr <= 1'b0;
                            ov_descriptor   <= '0;
                            state           <= IDLE_S;
                        end
                    end else if (ACK_TIMEOUT > 0 && timer == TMR_LAST) begin
                        o_descriptor_wr <= 1'b0;
                        ov_descriptor   <= '0;
                        ov_timeout_cnt  <= sat_inc(ov_timeout_cnt);
                        state           <= IDLE_S;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    o_descriptor_wr <= 1'b0;
                    ov_descriptor   <= '0;
                    state           <= IDLE_S;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_descriptor_send_queue.sv
// Directed bench for descriptor_send_queue: stimulus pushes expected descriptors and
// buffer IDs into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_descriptor_send_queue;
    localparam int DES_W   = 72;
    localparam int BUFID_W = 9;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               des_valid;
    logic [DES_W-1:0]   des_in;
    logic               bid_wr_in;
    logic [BUFID_W-1:0] bid_in;
    logic               bid_ack;
    logic               bid_wr_out;
    logic [BUFID_W-1:0] bid_out;
    logic               des_wr;
    logic [DES_W-1:0]   des_out;
    logic               des_ack;
    logic [$clog2(DEPTH):0] used;
    logic [CNT_W-1:0]   nobufid_cnt;
    logic [CNT_W-1:0]   full_cnt;
    logic [CNT_W-1:0]   timeout_cnt;
    logic [1:0]         send_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DES_W-1:0]   exp_q[$];
    logic [BUFID_W-1:0] bid_q[$];
    logic prev_wr;
    logic prev_ack;

    always #5 clk = ~clk;

    descriptor_send_queue #(
        .DES_W(DES_W), .BUFID_W(BUFID_W), .DEPTH(DEPTH), .ACK_TIMEOUT(8), .CNT_W(CNT_W)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_descriptor_valid  (des_valid),
        .iv_descriptor       (des_in),
        .i_pkt_bufid_wr      (bid_wr_in),
        .iv_pkt_bufid        (bid_in),
        .o_pkt_bufid_ack     (bid_ack),
        .o_pkt_bufid_wr      (bid_wr_out),
        .ov_pkt_bufid        (bid_out),
        .o_descriptor_wr     (des_wr),
        .ov_descriptor       (des_out),
        .i_descriptor_ack    (des_ack),
        .ov_queue_used       (used),
        .ov_nobufid_drop_cnt (nobufid_cnt),
        .ov_full_drop_cnt    (full_cnt),
        .ov_timeout_cnt      (timeout_cnt),
        .ov_send_state       (send_state)
    );

    task automatic check(input string name, input logic [DES_W-1:0] act, input logic [DES_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DES_W-1:0] d, input logic [BUFID_W-1:0] b,
                        input logic bw, input logic accept, input logic [DES_W-1:0] exp_d);
        des_valid = 1'b1;
        des_in    = d;
        bid_in    = b;
        bid_wr_in = bw;
        if (accept) begin
            exp_q.push_back(exp_d);
            bid_q.push_back(b);
        end
        step();
        des_valid = 1'b0;
        bid_wr_in = 1'b0;
        des_in    = '0;
        bid_in    = '0;
    endtask

    // A descriptor is new when wr rises or when the previous one was acked while wr stays high.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (des_wr && (!prev_wr || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL desc_unexpected: got %0h expected none", des_out);
                end else begin
                    check("desc_out", des_out, exp_q.pop_front());
                end
            end
            prev_wr  = des_wr;
            prev_ack = des_ack;
            if (bid_wr_out) begin
                check("bufid_ack_pulse", 72'(bid_ack), 72'd1);
                if (bid_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bufid_unexpected: got %0h expected none", bid_out);
                end else begin
                    check("bufid_out", 72'(bid_out), 72'(bid_q.pop_front()));
                end
            end else begin
                check("bufid_ack_idle", 72'(bid_ack), 72'd0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        des_valid = 1'b0;
        des_in    = '0;
        bid_wr_in = 1'b0;
        bid_in    = '0;
        des_ack   = 1'b0;
        step();
        step();
        check("rst_wr", 72'(des_wr), 72'd0);
        check("rst_desc", des_out, 72'd0);
        check("rst_used", 72'(used), 72'd0);
        check("rst_state", 72'(send_state), 72'd0);
        rst_n = 1'b1;
        step();

        // Single descriptor; low 9 bits 0x1FF replaced by bufid 5.
        send(72'hAB_0000_0000_0000_01FF, 9'h005, 1'b1, 1'b1, 72'hAB_0000_0000_0000_0005);
        check("t1_bid_ack", 72'(bid_ack), 72'd1);
        check("t1_bid_val", 72'(bid_out), 72'h005);
        check("t1_wr_early", 72'(des_wr), 72'd0);
        step();
        check("t1_bid_ack_off", 72'(bid_ack), 72'd0);
        check("t1_bid_zero", 72'(bid_out), 72'd0);
        check("t1_wr", 72'(des_wr), 72'd1);
        check("t1_desc", des_out, 72'hAB_0000_0000_0000_0005);
        check("t1_state_wait", 72'(send_state), 72'h2);
        step();
        step();
        des_ack = 1'b1;
        step();
        des_ack = 1'b0;
        check("t1_wr_low", 72'(des_wr), 72'd0);
        check("t1_desc_zero", des_out, 72'd0);
        check("t1_state_idle", 72'(send_state), 72'd0);

        // No buffer ID offered.
        for (int i = 0; i < 3; i++) send(72'h12_3456_789A_BCDE_F012, 9'h0AA, 1'b0, 1'b0, '0);
        step();
        check("t2_nobufid", 72'(nobufid_cnt), 72'd3);
        check("t2_used", 72'(used), 72'd0);
        check("t2_wr", 72'(des_wr), 72'd0);

        // Fill and overflow with ack held low.
        send(72'h31_2222_3333_4444_5FFF, 9'h000, 1'b1, 1'b1, 72'h31_2222_3333_4444_5E00);
        send(72'h32_2222_3333_4444_5FFF, 9'h001, 1'b1, 1'b1, 72'h32_2222_3333_4444_5E01);
        send(72'h33_2222_3333_4444_5FFF, 9'h002, 1'b1, 1'b1, 72'h33_2222_3333_4444_5E02);
        send(72'h34_2222_3333_4444_5FFF, 9'h003, 1'b1, 1'b1, 72'h34_2222_3333_4444_5E03);
        send(72'h35_2222_3333_4444_5FFF, 9'h004, 1'b1, 1'b1, 72'h35_2222_3333_4444_5E04);
        send(72'h36_2222_3333_4444_5FFF, 9'h005, 1'b1, 1'b0, '0);
        check("t3_full_drop", 72'(full_cnt), 72'd1);
        check("t3_used_full", 72'(used), 72'd4);
        check("t3_no_ack", 72'(bid_ack), 72'd0);

        // Push at full while the head is popped by an ack on the same edge.
        des_ack = 1'b1;
        send(72'h37_2222_3333_4444_5FFF, 9'h006, 1'b1, 1'b1, 72'h37_2222_3333_4444_5E06);
        check("t5_used_stays", 72'(used), 72'd4);
        check("t5_no_full_drop", 72'(full_cnt), 72'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_b2b_wr", 72'(des_wr), 72'd1);
            step();
        end
        des_ack = 1'b0;
        check("t3_drain_wr", 72'(des_wr), 72'd0);
        check("t3_drain_used", 72'(used), 72'd0);
        check("t3_drain_state", 72'(send_state), 72'd0);

        // Ack timeout of 8 cycles.
        send(72'h00_DEAD_BEEF_0000_0123, 9'h1AB, 1'b1, 1'b1, 72'h00_DEAD_BEEF_0000_01AB);
        step();
        check("t4_wr_start", 72'(des_wr), 72'd1);
        for (int i = 0; i < 7; i++) step();
        check("t4_wr_last", 72'(des_wr), 72'd1);
        check("t4_cnt_before", 72'(timeout_cnt), 72'd0);
        step();
        check("t4_wr_dropped", 72'(des_wr), 72'd0);
        check("t4_cnt", 72'(timeout_cnt), 72'd1);
        check("t4_state", 72'(send_state), 72'd0);

        // Ack on the final timeout cycle wins.
        send(72'hFF_FFFF_FFFF_FFFF_FFFF, 9'h000, 1'b1, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FE00);
        step();
        for (int i = 0; i < 7; i++) step();
        check("t4b_wr_last", 72'(des_wr), 72'd1);
        des_ack = 1'b1;
        step();
        des_ack = 1'b0;
        check("t4b_wr_low", 72'(des_wr), 72'd0);
        check("t4b_cnt_same", 72'(timeout_cnt), 72'd1);

        // Reset mid-operation with three queued and one in flight.
        send(72'h0A_0000_0000_0000_0000, 9'h010, 1'b1, 1'b1, 72'h0A_0000_0000_0000_0010);
        send(72'h0B_0000_0000_0000_0000, 9'h011, 1'b1, 1'b1, 72'h0B_0000_0000_0000_0011);
        send(72'h0C_0000_0000_0000_0000, 9'h012, 1'b1, 1'b1, 72'h0C_0000_0000_0000_0012);
        send(72'h0D_0000_0000_0000_0000, 9'h013, 1'b1, 1'b1, 72'h0D_0000_0000_0000_0013);
        check("t6_used_pre", 72'(used), 72'd3);
        check("t6_state_pre", 72'(send_state), 72'h2);
        rst_n = 1'b0;
        exp_q.delete();
        bid_q.delete();
        #1;
        check("t6_wr", 72'(des_wr), 72'd0);
        check("t6_desc", des_out, 72'd0);
        check("t6_used", 72'(used), 72'd0);
        check("t6_state", 72'(send_state), 72'd0);
        check("t6_bid_ack", 72'(bid_ack), 72'd0);
        check("t6_nobufid", 72'(nobufid_cnt), 72'd0);
        check("t6_full", 72'(full_cnt), 72'd0);
        check("t6_timeout", 72'(timeout_cnt), 72'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t6_no_stale_wr", 72'(des_wr), 72'd0);
        check("t6_used_after", 72'(used), 72'd0);

        check("exp_q_drained", 72'(exp_q.size()), 72'd0);
        check("bid_q_drained", 72'(bid_q.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/descriptor_send_queue.md
Name: descriptor_send_queue

Overview:
Parametrised next-generation descriptor sender for the network input path. It pairs each incoming descriptor with the packet buffer ID allocated for it and overwrites the descriptor's low BUFID_W bits with that ID. Merged descriptors go into a DEPTH-entry queue, so upstream is not stalled while the downstream consumer withholds its ack. It adds an optional ack timeout and saturating drop/timeout statistics.

Parameters:
DES_W, 72, descriptor width; bits [BUFID_W-1:0] carry the buffer ID
BUFID_W, 9, packet buffer ID width
DEPTH, 4, queue entries; power of two, >=2
ACK_TIMEOUT, 0, cycles to wait for i_descriptor_ack before dropping; 0 disables the timeout
CNT_W, 16, statistics counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_descriptor_valid  in  1  descriptor present this cycle (single-cycle pulse)
iv_descriptor  in  DES_W  descriptor from extractor
i_pkt_bufid_wr  in  1  buffer ID valid
iv_pkt_bufid  in  BUFID_W  allocated buffer ID
o_pkt_bufid_ack  out  1  buffer ID consumed (1-cycle pulse)
o_pkt_bufid_wr  out  1  buffer ID forwarded to packet write path (1-cycle pulse)
ov_pkt_bufid  out  BUFID_W  forwarded buffer ID; 0 when not valid
o_descriptor_wr  out  1  descriptor valid toward the queue manager; held until ack
ov_descriptor  out  DES_W  merged descriptor; 0 when not valid
i_descriptor_ack  in  1  downstream accepted the descriptor
ov_queue_used  out  log2(DEPTH)+1  occupied entries
ov_nobufid_drop_cnt  out  CNT_W  descriptors dropped because no buffer ID was offered
ov_full_drop_cnt  out  CNT_W  descriptors dropped because the queue was full
ov_timeout_cnt  out  CNT_W  descriptors dropped by ack timeout
ov_send_state  out  2  egress FSM state: 2'b00 idle_s, 2'b10 wait_des_ack_s

Behaviour:
- Reset (async, active-low): all outputs 0, queue emptied, pointers and counters cleared, FSM idle_s. Reset asserted mid-transfer loses all queued entries; no ack is generated.
- Ingress is evaluated every cycle, independently of the egress FSM.
  - valid & bufid_wr & queue not full: push {iv_descriptor[DES_W-1:BUFID_W], iv_pkt_bufid}. Next cycle: o_pkt_bufid_ack=1, o_pkt_bufid_wr=1, ov_pkt_bufid=iv_pkt_bufid, each for exactly one cycle.
  - valid & !bufid_wr: descriptor dropped; ov_nobufid_drop_cnt+1; no ack.
  - valid & bufid_wr & queue full: descriptor dropped; ov_full_drop_cnt+1; no bufid ack, so upstream keeps the buffer ID.
  - bufid_wr without valid: ignored; no ack.
- Queue: register-based circular buffer with wrapping pointers.
  - Push and pop in the same cycle are both allowed. Pushing when full is allowed only if a pop occurs that same cycle.
  - ov_queue_used updates on the edge after the push or pop.
- Egress FSM:
  - idle_s: if queue non-empty, pop the head, drive o_descriptor_wr=1 and ov_descriptor=head, clear the timer, go to wait_des_ack_s.
  - wait_des_ack_s: hold o_descriptor_wr and ov_descriptor stable.
    - On i_descriptor_ack: if the queue is non-empty, pop and present the next entry at the same edge (o_descriptor_wr stays 1, back-to-back) and stay. Otherwise clear both outputs to 0 and go to idle_s.
    - If ACK_TIMEOUT>0 and the timer reaches ACK_TIMEOUT-1 with no ack: drop the entry, ov_timeout_cnt+1, clear outputs, go to idle_s. Ack on that same cycle wins (counted as accepted, not as a timeout).
  - Undefined state: outputs 0, go to idle_s.
- Latency: input pulse at edge N is pushed at N; o_descriptor_wr rises after edge N+1 when the FSM is idle and the queue was empty.
- Counters: unsigned and saturating at 2^CNT_W-1; never wrap.
- Arithmetic: ov_descriptor[BUFID_W-1:0] always equals the paired buffer ID; upper bits pass through unchanged.

Test Plan:
- Single descriptor: valid=1, bufid_wr=1, desc=72'hAB_0000_0000_0000_01FF, bufid=9'h05 -> next cycle bufid_ack=1, ov_pkt_bufid=5; a cycle later o_descriptor_wr=1 with ov_descriptor[8:0]=9'h005 and upper bits unchanged; ack after 3 cycles -> wr=0, state 00.
- No buffer ID: valid=1, bufid_wr=0 three times -> no acks, ov_nobufid_drop_cnt=3, queue_used=0.
- Fill and overflow (DEPTH=4, ack held 0): 6 back-to-back pairs -> 5 acked (1 in egress register, 4 queued), ov_full_drop_cnt=1, ov_queue_used=4; then ack continuously -> o_descriptor_wr stays high for 5 consecutive descriptors in arrival order, bufids 0..4.
- Timeout: ACK_TIMEOUT=8, one descriptor, ack never asserted -> o_descriptor_wr drops after 8 cycles in wait state, ov_timeout_cnt=1; ack on cycle 8 in a rerun -> counter unchanged.
- Simultaneous push/pop at full: queue holds 4 and ack arrives the same cycle as a new valid pair -> push accepted, no full drop, queue_used stays 4.
- Reset mid-operation: queue holds 3 and wait_des_ack_s is active; assert i_rst_n=0 -> all outputs and counters 0 immediately; after release no stale descriptor is emitted.
